// File: rtl/raster_to_block.sv
// Raster-to-block converter: buffers 8 raster lines in ping-pong banks and emits 8x8 blocks
// as row words tagged with start-of-block, end-of-block and start-of-frame markers.
module raster_to_block #(
  parameter int unsigned W_IO         = 16,
  parameter int unsigned BLK_PER_LINE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0][W_IO-1:0] in_data,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0][W_IO-1:0] out_data,
  output logic                 out_sob,
  output logic                 out_eob,
  output logic                 out_sof
);

  localparam int unsigned CW = (BLK_PER_LINE > 1) ? $clog2(BLK_PER_LINE) : 1;
  localparam logic [CW-1:0] LastCol = CW'(BLK_PER_LINE - 1);

  logic [7:0][W_IO-1:0] mem [2][8][BLK_PER_LINE];

  logic [1:0]    full_q, full_d;
  logic [1:0]    sof_flag_q;
  logic          wr_bank_q;
  logic [2:0]    wr_line_q;
  logic [CW-1:0] wr_col_q;
  logic          rd_bank_q;
  logic [2:0]    rd_row_q;
  logic [CW-1:0] rd_blk_q;

  logic          accept, load, wr_last, rd_last;
  logic [2:0]    wr_line_eff;
  logic [CW-1:0] wr_col_eff;

  assign in_ready = ~full_q[wr_bank_q];
  assign accept   = en & in_valid & in_ready;

  // A start-of-frame word restarts the current bank at line 0, column 0.
  assign wr_line_eff = in_sof ? 3'd0 : wr_line_q;
  assign wr_col_eff  = in_sof ? '0 : wr_col_q;
  assign wr_last     = (wr_line_eff == 3'd7) && (wr_col_eff == LastCol);

  assign load    = en & full_q[rd_bank_q] & (~out_valid | out_ready);
  assign rd_last = (rd_row_q == 3'd7) && (rd_blk_q == LastCol);

  // Writer only touches a non-full bank and reader only a full one, so they never collide.
  always_comb begin
    full_d = full_q;
    if (accept && wr_last) full_d[wr_bank_q] = 1'b1;
    if (load && rd_last)   full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank_q][wr_line_eff][wr_col_eff] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      sof_flag_q <= '0;
      wr_bank_q  <= 1'b0;
      wr_line_q  <= '0;
      wr_col_q   <= '0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        if ((wr_line_eff == 3'd0) && (wr_col_eff == '0)) sof_flag_q[wr_bank_q] <= in_sof;
        if (wr_last) begin
          wr_bank_q <= ~wr_bank_q;
          wr_line_q <= '0;
          wr_col_q  <= '0;
        end else if (wr_col_eff == LastCol) begin
          wr_col_q  <= '0;
          wr_line_q <= wr_line_eff + 3'd1;
        end else begin
          wr_col_q  <= wr_col_eff + CW'(1);
          wr_line_q <= wr_line_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q <= 1'b0;
      rd_row_q  <= '0;
      rd_blk_q  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_sof   <= 1'b0;
    end else if (load) begin
      out_data  <= mem[rd_bank_q][rd_row_q][rd_blk_q];
      out_sob   <= (rd_row_q == 3'd0);
      out_eob   <= (rd_row_q == 3'd7);
      out_sof   <= (rd_row_q == 3'd0) && (rd_blk_q == '0) && sof_flag_q[rd_bank_q];
      out_valid <= 1'b1;
      if (rd_last) begin
        rd_bank_q <= ~rd_bank_q;
        rd_row_q  <= '0;
        rd_blk_q  <= '0;
      end else if (rd_row_q == 3'd7) begin
        rd_row_q <= '0;
        rd_blk_q <= rd_blk_q + CW'(1);
      end else begin
        rd_row_q <= rd_row_q + 3'd1;
      end
    end else if (en && out_valid && out_ready) begin
      // Row consumed with nothing to replace it; data is left as-is.
      out_valid <= 1'b0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_sof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raster_to_block.sv
// Directed bench for raster_to_block with BLK_PER_LINE=2, W_IO=16.
module tb_raster_to_block;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [7:0][15:0] in_data;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [7:0][15:0] out_data;
  logic             out_sob;
  logic             out_eob;
  logic             out_sof;

  typedef struct {
    logic [7:0][15:0] data;
    logic             sob;
    logic             eob;
    logic             sof;
    int               cyc;
  } row_t;

  row_t rows[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   stalls = 0;

  raster_to_block #(
    .W_IO        (16),
    .BLK_PER_LINE(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sob  (out_sob),
    .out_eob  (out_eob),
    .out_sof  (out_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Pixel value: stripe*2048 + line*256 + word_col*8 + lane
  function automatic logic [7:0][15:0] pix(input int s, input int ln, input int col);
    for (int j = 0; j < 8; j++) pix[j] = 16'(s * 2048 + ln * 256 + col * 8 + j);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input int ln, input int col, input bit sof);
    bit done;
    int guard;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = pix(s, ln, col);
    done     = 1'b0;
    guard    = 0;
    while (!done && guard < 300) begin
      @(negedge clk);
      done = in_ready && en;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!done) check("push timeout", 128'(done), 128'(1));
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic push_stripe(input int s, input bit sof);
    for (int ln = 0; ln < 8; ln++)
      for (int col = 0; col < 2; col++) push(s, ln, col, sof && ln == 0 && col == 0);
  endtask

  task automatic wait_rows(input int n, input string tag);
    int g;
    g = 0;
    while (rows.size() < n && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    check(tag, 128'(rows.size() >= n), 128'(1));
  endtask

  task automatic check_stripe(input int s, input bit sof_first, input string tag);
    row_t r;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 8; k++) begin
        if (rows.size() == 0) begin
          check($sformatf("%s row avail", tag), 128'(rows.size()), 128'(1));
          return;
        end
        r = rows.pop_front();
        check($sformatf("%s b%0d r%0d data", tag, b, k), r.data, pix(s, k, b));
        check($sformatf("%s b%0d r%0d sob", tag, b, k), 128'(r.sob), 128'(k == 0));
        check($sformatf("%s b%0d r%0d eob", tag, b, k), 128'(r.eob), 128'(k == 7));
        check($sformatf("%s b%0d r%0d sof", tag, b, k), 128'(r.sof),
              128'(sof_first && k == 0 && b == 0));
      end
    end
  endtask

  initial begin
    int first_cyc;
    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (out_valid && out_ready && en)
          rows.push_back('{data: out_data, sob: out_sob, eob: out_eob, sof: out_sof, cyc: cyc});
        if (in_valid && !in_ready) stalls++;
      end
    join_none

    // Reset values
    #3;
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_sob", 128'(out_sob), 128'(0));
    check("rst out_eob", 128'(out_eob), 128'(0));
    check("rst out_sof", 128'(out_sof), 128'(0));
    check("rst out_data", out_data, 128'(0));
    check("rst in_ready", 128'(in_ready), 128'(1));
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A: single stripe, latency and contents
    push_stripe(0, 1'b1);
    check("A valid at last accept", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;
    check("A valid one cycle later", 128'(out_valid), 128'(1));
    wait_rows(16, "A rows");
    check_stripe(0, 1'b1, "A");

    // B: three back-to-back stripes with out_ready high
    stalls = 0;
    push_stripe(1, 1'b1);
    push_stripe(2, 1'b0);
    push_stripe(3, 1'b0);
    wait_rows(48, "B rows");
    check("B in_ready never low", 128'(stalls), 128'(0));
    if (rows.size() >= 48) check("B contiguous", 128'(rows[47].cyc - rows[0].cyc), 128'(47));
    check_stripe(1, 1'b1, "B1");
    check_stripe(2, 1'b0, "B2");
    check_stripe(3, 1'b0, "B3");

    // C: downstream stalled, both banks fill
    out_ready = 1'b0;
    push_stripe(4, 1'b0);
    push_stripe(5, 1'b0);
    check("C in_ready after 32", 128'(in_ready), 128'(0));
    check("C out_valid held", 128'(out_valid), 128'(1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("C out_data held", out_data, pix(4, 0, 0));
    check("C out_sob held", 128'(out_sob), 128'(1));
    check("C no transfers", 128'(rows.size()), 128'(0));
    out_ready = 1'b1;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    check("C in_ready before row16", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    check("C in_ready after row16", 128'(in_ready), 128'(1));
    push_stripe(6, 1'b0);
    wait_rows(48, "C rows");
    check_stripe(4, 1'b0, "C4");
    check_stripe(5, 1'b0, "C5");
    check_stripe(6, 1'b0, "C6");

    // D: partial stripe discarded by a new start-of-frame
    for (int ln = 0; ln < 3; ln++)
      for (int col = 0; col < 2; col++) push(7, ln, col, 1'b0);
    push_stripe(8, 1'b1);
    wait_rows(16, "D rows");
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("D single stripe", 128'(rows.size()), 128'(16));
    check_stripe(8, 1'b1, "D");

    // E: enable dropped mid-input and mid-output
    for (int w = 0; w < 16; w++) begin
      if (w == 5) begin
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = pix(9, 2, 1);
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        check("E out_valid idle", 128'(out_valid), 128'(0));
        en = 1'b1;
      end
      push(9, w / 2, w % 2, w == 0);
    end
    wait_rows(4, "E first rows");
    check("E rows before hold", 128'(rows.size()), 128'(4));
    en = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("E hold valid", 128'(out_valid), 128'(1));
    check("E hold data", out_data, pix(9, 4, 0));
    check("E hold sob", 128'(out_sob), 128'(0));
    check("E hold rows", 128'(rows.size()), 128'(4));
    en = 1'b1;
    wait_rows(16, "E rows");
    check_stripe(9, 1'b1, "E");

    // R: asynchronous reset mid-stream
    out_ready = 1'b0;
    push_stripe(10, 1'b1);
    for (int w = 0; w < 4; w++) push(11, w / 2, w % 2, 1'b0);
    check("R valid before reset", 128'(out_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("R out_valid", 128'(out_valid), 128'(0));
    check("R out_data", out_data, 128'(0));
    check("R out_sob", 128'(out_sob), 128'(0));
    check("R out_sof", 128'(out_sof), 128'(0));
    check("R in_ready", 128'(in_ready), 128'(1));
    rows.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_stripe(12, 1'b1);
    wait_rows(16, "R rows");
    check_stripe(12, 1'b1, "R");
    first_cyc = cyc;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("R no extra rows", 128'(rows.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_to_block.md
# raster_to_block

Raster-to-block converter that produces the 8x8 block row stream consumed by the matrix buffering and DCT stages of the JPEG_MOD pipeline. It accepts a raster pixel stream, 8 pixels per word, and collects 8 image lines in one of two ping-pong line banks. It then emits each 8x8 block as 8 consecutive row words, tagged with the start-of-block, end-of-block and start-of-frame markers used on the block interface. Backpressure is supported on both sides.

## Interface
- W_IO, 16, pixel/sample width in bits.
- BLK_PER_LINE, 4, 8-pixel words per image line, which equals blocks per stripe (≥1). Counter widths are $clog2(BLK_PER_LINE), minimum 1.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global enable. When low, all state and outputs hold.
- in_valid  in  1  in_data word valid.
- in_ready  out  1  input word accepted on cycle where in_valid & in_ready & en.
- in_data  in  [7:0][W_IO-1:0]  8 horizontally adjacent pixels; lane 0 is leftmost.
- in_sof  in  1  first word of a frame (line 0, column 0).
- out_valid  out  1  out_data row valid.
- out_ready  in  1  downstream accepts the row when out_valid & out_ready & en.
- out_data  out  [7:0][W_IO-1:0]  one block row.
- out_sob  out  1  row 0 of a block.
- out_eob  out  1  row 7 of a block.
- out_sof  out  1  row 0 of block 0 of the first stripe of a frame.

## Operation
- Storage: bank[2][8 lines][BLK_PER_LINE] words, plus full[2] and sof_flag[2]. Storage words are not reset.
- Write side: wr_bank, wr_line (0..7), wr_col (0..BLK_PER_LINE-1). in_ready = ~full[wr_bank].
- Accepted word: bank[wr_bank][wr_line][wr_col] <= in_data. wr_col increments. On wr_col wrap, wr_line increments.
- Accepted word with in_sof = 1: written at line 0, column 0 regardless of the current pointers. Any partial stripe in wr_bank is discarded. Pointers continue from column 1.
- Every accepted write at line 0, column 0 sets sof_flag[wr_bank] <= in_sof.
- Accepted word at line 7, column BLK_PER_LINE-1: full[wr_bank] <= 1, wr_bank toggles, pointers reset to 0.
- Read side: rd_bank, rd_blk, rd_row. Emission order is block 0 rows 0..7, then block 1 rows 0..7, and so on. Each row is bank[rd_bank][rd_row][rd_blk].
- load = en & full[rd_bank] & (~out_valid | out_ready).
- On load, output registers capture:
  - out_data = the row above
  - out_sob = (rd_row==0)
  - out_eob = (rd_row==7)
  - out_sof = (rd_row==0 & rd_blk==0 & sof_flag[rd_bank])
  - out_valid = 1
- After each load, rd_row increments. On wrap, rd_blk increments.
- Load of the last row of the last block: full[rd_bank] <= 0, rd_bank toggles, pointers reset to 0.
- en & out_valid & out_ready & ~load: out_valid <= 0 and out_sob/out_eob/out_sof <= 0. out_data holds.
- out_valid & ~out_ready: all outputs hold stable.
- Setting full[wr_bank] and clearing full[rd_bank] in the same cycle is legal. The two cannot target the same bank.

## Timing
- Reset values: out_valid, out_sob, out_eob, out_sof = 0; out_data = 0; in_ready = 1. Both banks are empty; all pointers and sof_flags are 0.
- Latency: last word of a stripe accepted at edge T → first row visible after edge T+1, if en=1 and the output register is free.
- Throughput: one word in and one row out per enabled cycle. A stripe drains in 8*BLK_PER_LINE loads.
- With out_ready held at 1, continuous input never deasserts in_ready.
- in_ready drops only when both banks are full. It rises the cycle after the last row of rd_bank is loaded.
- en low: no pointer, flag or output changes. Handshakes are not evaluated.
- Reset mid-operation discards all buffered stripes. Outputs return to reset values asynchronously.

## Test plan
- Reset: assert rst_n low mid-stream → outputs 0, in_ready=1 immediately; the next stripe restarts at bank 0.
- BLK_PER_LINE=2, W_IO=16, pixel value = line*256 + col*8 + lane. Feed one frame stripe of 16 words with in_sof on word 0 → 16 rows emitted:
  - row k of block b has lane j = k*256 + b*8 + j
  - out_sof=1 only on row 0 of block 0
  - out_sob/out_eob on rows 0/7
  - first out_valid one cycle after last input
- Three stripes back-to-back, out_ready=1 → in_ready stays 1; 48 contiguous output rows; out_sof only on the first row.
- out_ready=0 held, feed 3 stripes → in_ready falls after word 32. out_data holds the first row. Raising out_ready gives in_ready=1 one cycle after row 16 loads; no data lost.
- Feed 3 lines, then a word with in_sof=1 followed by 15 more → one stripe out containing only post-sof data, with out_sof=1 on its first row.
- Toggle en low for 5 cycles mid-input and mid-output → no state advance; output sequence identical to the en=1 run.
